// File: rtl/fs_detector_cal.sv
// Gen2 RX frame-sync / preamble detector: measures delimiter, data-0, RTcal and
// TRcal intervals on the PIE input and exports sync plus calibration values.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for the falling edge that opens a delimiter
// S_DELIM  | timing the delimiter low period
// S_DATA0  | timing data-0, rise to rise
// S_RTCAL  | timing RTcal, rise to rise; ratio checked against data-0
// S_CLASS  | sync held; next interval decides TRcal vs data symbol
// S_LOCKED | calibration held until package_complete
module fs_detector_cal #(
  parameter int CNT_W     = 10,
  parameter int DELIM_MIN = 10,
  parameter int DELIM_MAX = 15,
  parameter int TIMEOUT   = 1000,
  parameter int TRCAL_EN  = 1
) (
  input  logic             clk_fsd,
  input  logic             rst,
  input  logic             pie_code,
  input  logic             package_complete,
  output logic             sync,
  output logic             preamble,
  output logic             cal_vld,
  output logic [CNT_W-1:0] rtcal,
  output logic [CNT_W-1:0] trcal,
  output logic [CNT_W-1:0] pivot,
  output logic             fs_error
);

  localparam int CW = CNT_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELIM,
    S_DATA0,
    S_RTCAL,
    S_CLASS,
    S_LOCKED
  } state_t;

  state_t           state;
  logic             pie_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] d0;

  logic          fall;
  logic          rise;
  logic          tmo;
  logic          delim_ok;
  logic          rt_ok;
  logic [CW-1:0] cnt_x;
  logic [CW-1:0] d0_x2;
  logic [CW-1:0] d0_x3;
  logic [CW-1:0] rt_x1;
  logic [CW-1:0] rt_x3;

  assign fall  = pie_q & ~pie_code;
  assign rise  = ~pie_q & pie_code;
  assign cnt_x = CW'(cnt);
  assign d0_x2 = CW'(d0) << 1;
  assign d0_x3 = d0_x2 + CW'(d0);
  assign rt_x1 = CW'(rtcal);
  assign rt_x3 = (rt_x1 << 1) + rt_x1;

  // Fires on the edge where cnt steps onto TIMEOUT, so fs_error and cnt == TIMEOUT coincide.
  assign tmo      = (cnt == CNT_W'(TIMEOUT - 1));
  assign delim_ok = (cnt_x >= CW'(DELIM_MIN)) && (cnt_x <= CW'(DELIM_MAX));
  assign rt_ok    = (cnt_x > d0_x2) && (cnt_x <= d0_x3);

  always_ff @(posedge clk_fsd) begin
    if (rst) begin
      state    <= S_IDLE;
      pie_q    <= 1'b1;
      cnt      <= '0;
      d0       <= '0;
      sync     <= 1'b0;
      preamble <= 1'b0;
      cal_vld  <= 1'b0;
      rtcal    <= '0;
      trcal    <= '0;
      pivot    <= '0;
      fs_error <= 1'b0;
    end else begin
      pie_q    <= pie_code;
      cal_vld  <= 1'b0;
      fs_error <= 1'b0;
      if (cnt != '1) cnt <= cnt + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (fall) begin
            cnt   <= '0;
            state <= S_DELIM;
          end
        end

        S_DELIM: begin
          if (tmo) begin
            fs_error <= 1'b1;
            state    <= S_IDLE;
          end else if (rise) begin
            if (delim_ok) begin
              cnt   <= '0;
              state <= S_DATA0;
            end else begin
              fs_error <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end

        S_DATA0: begin
          if (tmo) begin
            fs_error <= 1'b1;
            state    <= S_IDLE;
          end else if (rise) begin
            d0    <= cnt;
            cnt   <= '0;
            state <= S_RTCAL;
          end
        end

        S_RTCAL: begin
          if (tmo) begin
            fs_error <= 1'b1;
            state    <= S_IDLE;
          end else if (rise) begin
            if (!rt_ok) begin
              fs_error <= 1'b1;
              state    <= S_IDLE;
            end else begin
              rtcal <= cnt;
              pivot <= cnt >> 1;
              cnt   <= '0;
              sync  <= 1'b1;
              if (TRCAL_EN != 0) begin
                state <= S_CLASS;
              end else begin
                preamble <= 1'b0;
                trcal    <= '0;
                cal_vld  <= 1'b1;
                state    <= S_LOCKED;
              end
            end
          end
        end

        S_CLASS: begin
          if (tmo) begin
            fs_error <= 1'b1;
            sync     <= 1'b0;
            state    <= S_IDLE;
          end else if (package_complete) begin
            sync     <= 1'b0;
            preamble <= 1'b0;
            state    <= S_IDLE;
          end else if (rise) begin
            if (cnt_x > rt_x3) begin
              fs_error <= 1'b1;
              sync     <= 1'b0;
              state    <= S_IDLE;
            end else if (cnt_x > rt_x1) begin
              trcal    <= cnt;
              preamble <= 1'b1;
              cal_vld  <= 1'b1;
              state    <= S_LOCKED;
            end else begin
              trcal    <= '0;
              preamble <= 1'b0;
              cal_vld  <= 1'b1;
              state    <= S_LOCKED;
            end
          end
        end

        S_LOCKED: begin
          if (package_complete) begin
            sync     <= 1'b0;
            preamble <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fs_detector_cal.md
Name: fs_detector_cal

Overview:
- Parametrised successor to the single-bit frame-sync detector for the Gen2 RX path.
- Measures the delimiter, data-0, RTcal and optional TRcal intervals of the incoming PIE stream in clk_fsd cycles.
- Validates each interval against Gen2 ratio rules and tells preamble from frame-sync.
- Exports sync, the calibration values and the data-decode pivot to the PIE decoder and the TX link-frequency generator.

Parameters:
- CNT_W, 10: width of the interval counter and of the rtcal/trcal/pivot outputs.
- DELIM_MIN, 10: minimum delimiter low time in cycles, inclusive.
- DELIM_MAX, 15: maximum delimiter low time in cycles, inclusive.
- TIMEOUT, 1000: cycle limit for any single measured interval; must be less than 2^CNT_W.
- TRCAL_EN, 1: 1 enables preamble/TRcal classification; 0 makes every valid sync a frame-sync.

Ports:
- clk_fsd  in  1  block clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pie_code  in  1  PIE input, already synchronous to clk_fsd; idle level high.
- package_complete  in  1  one-cycle pulse from the command parser at end of packet.
- sync  out  1  high while a valid frame-sync/preamble is locked.
- preamble  out  1  1 = locked on a preamble (TRcal valid); 0 = frame-sync only.
- cal_vld  out  1  one-cycle pulse when classification completes.
- rtcal  out  CNT_W  measured RTcal in cycles.
- trcal  out  CNT_W  measured TRcal in cycles; 0 when preamble = 0.
- pivot  out  CNT_W  rtcal >> 1; PIE data-0/data-1 decision threshold.
- fs_error  out  1  one-cycle pulse on any rejected interval or timeout.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, pie_q 1. rst dominates every other input.
- Edge detection: pie_q holds pie_code registered once.
  - fall = pie_q & ~pie_code; rise = ~pie_q & pie_code.
  - Interval counter cnt clears on the edge that starts a measurement, increments each cycle and saturates at all-ones.
- State machine:
  - IDLE: on fall, clear cnt and go to DELIM.
  - DELIM: on rise, check DELIM_MIN <= cnt <= DELIM_MAX. Pass: clear cnt, go to DATA0. Fail: pulse fs_error, go to IDLE.
  - DATA0: on rise, latch d0 = cnt, clear cnt, go to RTCAL.
  - RTCAL: on rise, check 2*d0 < cnt <= 3*d0, with comparisons at CNT_W+2 bits.
    - Fail: pulse fs_error, go to IDLE.
    - Pass: latch rtcal = cnt, pivot = cnt >> 1, clear cnt.
    - If TRCAL_EN = 1, go to CLASS.
    - If TRCAL_EN = 0, set sync, pulse cal_vld with preamble = 0, go to LOCKED.
    - sync, rtcal and pivot take effect in the cycle after the detected rise.
  - CLASS: sync = 1 throughout. On the next rise:
    - If cnt > rtcal and cnt <= 3*rtcal: trcal = cnt, preamble = 1, pulse cal_vld, go to LOCKED.
    - If cnt <= rtcal: the interval is a data symbol. preamble = 0, trcal = 0, pulse cal_vld, go to LOCKED.
    - If cnt > 3*rtcal: pulse fs_error, clear sync, go to IDLE.
  - LOCKED: sync held, calibration registers held. On package_complete, go to IDLE; sync and preamble clear on the next cycle, while rtcal, trcal and pivot keep their last values.
- Timeout: in DELIM, DATA0, RTCAL or CLASS, cnt reaching TIMEOUT pulses fs_error and returns to IDLE.
- Simultaneous events:
  - package_complete in CLASS is handled like package_complete in LOCKED: go to IDLE.
  - package_complete is ignored in IDLE, DELIM, DATA0 and RTCAL.
  - A rise and a timeout in the same cycle: timeout wins.
- fs_error and cal_vld are never high in the same cycle.
- A new delimiter is accepted only from IDLE. Falls in LOCKED are data symbols and are ignored.

Test Plan:
- Frame-sync, defaults: low 12, d0 = 20, rtcal = 50, then data interval 20 -> sync high the cycle after the RTcal rise; cal_vld with preamble = 0, rtcal = 50, pivot = 25, trcal = 0.
- Preamble: same stimulus with a third interval of 100 -> cal_vld, preamble = 1, trcal = 100; sync stays high until package_complete, then drops one cycle later.
- Delimiter bounds: low 9 and low 16 -> fs_error pulse, sync stays 0, state IDLE. Low 10 and low 15 -> accepted.
- RTcal ratio: d0 = 20 with rtcal = 40 and with rtcal = 61 -> fs_error. Rtcal = 41 and rtcal = 60 -> accepted. TRcal = 151 with rtcal = 50 -> fs_error and sync cleared.
- Timeout: hold pie_code high for 1000 cycles in DATA0 -> fs_error exactly when cnt reaches 1000, then state IDLE.
- Reset and mode: rst asserted in CLASS -> all outputs 0 on the next edge. With TRCAL_EN = 0 -> cal_vld in the cycle after the RTcal rise with preamble = 0.
